// File: rtl/io_change_detect.sv
// -----------------------------------------------------------------------------
// io_change_detect
//   Port change detector for the input side of a bidirectional I/O port.
//   Raw pin values are synchronized, compared against a snapshot taken at the
//   last CPU port read, and any difference on monitored bits must stay stable
//   for DEBOUNCE_CYCLES cycles before a sticky change flag (and irq) is raised.
//   A CPU read of the port re-arms the detector by re-taking the snapshot.
//
// Optional feature macro: IOC_CAUSE_CAPTURE_EN
//   When defined, adds a 'cause' output that accumulates the bits responsible
//   for each qualified change; cleared together with change_flag.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pin_in       in   [WIDTH] raw pad values
//   inout_sel    in   [WIDTH] direction per bit, 1 = input (monitored)
//   change_en    in   [WIDTH] per-bit change-detect enable
//   global_ie    in   interrupt enable
//   read_strobe  in   CPU port-read pulse (re-arms the detector)
//   flag_clear   in   clears change_flag (and cause)
//   port_value   out  [WIDTH] synchronized pin value
//   change_flag  out  sticky qualified-change flag
//   irq          out  change_flag & global_ie
//   busy         out  high while the detector is not idle
//   cause        out  [WIDTH] accumulated change bits (IOC_CAUSE_CAPTURE_EN only)
// -----------------------------------------------------------------------------
module io_change_detect #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] inout_sel,
  input  logic [WIDTH-1:0] change_en,
  input  logic             global_ie,
  input  logic             read_strobe,
  input  logic             flag_clear,
  output logic [WIDTH-1:0] port_value,
  output logic             change_flag,
  output logic             irq,
  output logic             busy
`ifdef IOC_CAUSE_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] cause
`endif
);

  // One extra bit over the minimum so DEBOUNCE_CYCLES-1 always fits.
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_ARMED    = 2'd2
  } state_e;

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] mismatch_s;
  logic [WIDTH-1:0] cand_diff_s;
  logic [WIDTH-1:0] cause_bits_s;

  state_e           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0] cand_r, cand_nxt_s;
  logic [WIDTH-1:0] snap_r, snap_nxt_s;
  logic             flag_r, flag_nxt_s;
  logic             set_s;
  logic             busy_r;

  // Pin synchronizer chain; the last stage is the port value seen by the CPU.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign sync_s       = sync_r[SYNC_STAGES-1];
  assign mask_s       = inout_sel & change_en;
  assign mismatch_s   = (sync_s ^ snap_r) & mask_s;
  assign cand_diff_s  = (sync_s ^ cand_r) & mask_s;
  assign cause_bits_s = (cand_r ^ snap_r) & mask_s;

  // Detector next-state: a port read overrides every FSM transition.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cand_nxt_s  = cand_r;
    snap_nxt_s  = snap_r;
    set_s       = 1'b0;
    if (read_strobe) begin
      snap_nxt_s  = sync_s;
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mismatch_s != {WIDTH{1'b0}}) begin
            state_nxt_s = ST_DEBOUNCE;
            cnt_nxt_s   = {CW{1'b0}};
            cand_nxt_s  = sync_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (mismatch_s == {WIDTH{1'b0}}) begin
            // Pin went back to the snapshot (or lost its mask bit): glitch.
            state_nxt_s = ST_IDLE;
          end else if (cand_diff_s != {WIDTH{1'b0}}) begin
            // Pins moved again mid-debounce: restart on the new value.
            cand_nxt_s = sync_s;
            cnt_nxt_s  = {CW{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            set_s       = 1'b1;
            state_nxt_s = ST_ARMED;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        ST_ARMED: begin
          state_nxt_s = ST_ARMED;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Sticky flag: a qualify in the same cycle as flag_clear wins.
  always_comb begin
    if (set_s) begin
      flag_nxt_s = 1'b1;
    end else if (flag_clear) begin
      flag_nxt_s = 1'b0;
    end else begin
      flag_nxt_s = flag_r;
    end
  end

  // Detector state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      cand_r  <= {WIDTH{1'b0}};
      snap_r  <= {WIDTH{1'b0}};
      flag_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      cand_r  <= cand_nxt_s;
      snap_r  <= snap_nxt_s;
      flag_r  <= flag_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

`ifdef IOC_CAUSE_CAPTURE_EN
  logic [WIDTH-1:0] cause_r, cause_nxt_s;

  // Cause accumulation: on a clear/qualify collision only the new bits remain.
  always_comb begin
    if (flag_clear) begin
      cause_nxt_s = set_s ? cause_bits_s : {WIDTH{1'b0}};
    end else if (set_s) begin
      cause_nxt_s = cause_r | cause_bits_s;
    end else begin
      cause_nxt_s = cause_r;
    end
  end

  // Cause register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cause_r <= {WIDTH{1'b0}};
    end else begin
      cause_r <= cause_nxt_s;
    end
  end

  assign cause = cause_r;
`else
  // Cause bits are only consumed when cause capture is built in.
  logic unused_cause_s;
  assign unused_cause_s = ^cause_bits_s;
`endif

  assign port_value  = sync_s;
  assign change_flag = flag_r;
  assign irq         = flag_r & global_ie;
  assign busy        = busy_r;

endmodule

// File: tb/tb_io_change_detect.sv
// -----------------------------------------------------------------------------
// tb_io_change_detect
//   Directed-vector self-checking bench for io_change_detect with default
//   parameters. Inputs change 1 time unit after a rising edge, so each new
//   value is captured by the following edge ("edge 1").
// -----------------------------------------------------------------------------
module tb_io_change_detect;

  logic       clock;
  logic       reset_n;
  logic [7:0] pin_in;
  logic [7:0] inout_sel;
  logic [7:0] change_en;
  logic       global_ie;
  logic       read_strobe;
  logic       flag_clear;
  logic [7:0] port_value;
  logic       change_flag;
  logic       irq;
  logic       busy;
`ifdef IOC_CAUSE_CAPTURE_EN
  logic [7:0] cause;
`endif

  int err_cnt;
  int chk_cnt;

  io_change_detect #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pin_in(pin_in),
    .inout_sel(inout_sel),
    .change_en(change_en),
    .global_ie(global_ie),
    .read_strobe(read_strobe),
    .flag_clear(flag_clear),
    .port_value(port_value),
    .change_flag(change_flag),
    .irq(irq),
    .busy(busy)
`ifdef IOC_CAUSE_CAPTURE_EN
    ,
    .cause(cause)
`endif
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One-edge pulse helpers.
  task automatic pulse_read();
    read_strobe = 1'b1;
    tick(1);
    read_strobe = 1'b0;
  endtask

  task automatic pulse_clear();
    flag_clear = 1'b1;
    tick(1);
    flag_clear = 1'b0;
  endtask

  initial begin
    err_cnt     = 0;
    chk_cnt     = 0;
    reset_n     = 1'b0;
    pin_in      = 8'h00;
    inout_sel   = 8'hFF;
    change_en   = 8'hFF;
    global_ie   = 1'b1;
    read_strobe = 1'b0;
    flag_clear  = 1'b0;

    // Reset state
    tick(2);
    check("rst_port", {24'h0, port_value}, 32'h0);
    check("rst_flag", {31'h0, change_flag}, 32'h0);
    check("rst_irq",  {31'h0, irq}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    tick(3);

    // Single-bit change 00 -> 01, flag after edge 7
    pin_in = 8'h01;
    tick(1);
    check("s_e1_port", {24'h0, port_value}, 32'h00);
    tick(1);
    check("s_e2_port", {24'h0, port_value}, 32'h01);
    check("s_e2_busy", {31'h0, busy}, 32'h0);
    tick(1);
    check("s_e3_busy", {31'h0, busy}, 32'h1);
    tick(3);
    check("s_e6_flag", {31'h0, change_flag}, 32'h0);
    tick(1);
    check("s_e7_flag", {31'h0, change_flag}, 32'h1);
    check("s_e7_irq",  {31'h0, irq}, 32'h1);
    check("s_e7_busy", {31'h0, busy}, 32'h1);
    global_ie = 1'b0;
    #1;
    check("s_ie0_irq", {31'h0, irq}, 32'h0);
    global_ie = 1'b1;
    #1;
    check("s_ie1_irq", {31'h0, irq}, 32'h1);

    // Re-arm with sync = 01: flag stays, detector idle, snapshot now 01
    pulse_read();
    check("ra_busy", {31'h0, busy}, 32'h0);
    check("ra_flag", {31'h0, change_flag}, 32'h1);
    tick(4);
    check("ra_idle", {31'h0, busy}, 32'h0);
    pulse_clear();
    check("clr_flag", {31'h0, change_flag}, 32'h0);
    check("clr_irq",  {31'h0, irq}, 32'h0);

    // Glitch on bit 4 held for 2 edges, then back to the snapshot value
    pin_in = 8'h11;
    tick(2);
    pin_in = 8'h01;
    tick(1);
    check("g_e3_busy", {31'h0, busy}, 32'h1);
    tick(2);
    check("g_e5_busy", {31'h0, busy}, 32'h0);
    tick(6);
    check("g_flag", {31'h0, change_flag}, 32'h0);
    check("g_busy", {31'h0, busy}, 32'h0);

    // Bit 0 configured as output: toggling it is ignored
    inout_sel = 8'hFE;
    pin_in    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("o_busy", {31'h0, busy}, 32'h0);
    end
    pin_in = 8'h01;
    tick(4);
    check("o_flag", {31'h0, change_flag}, 32'h0);
    check("o_busy2", {31'h0, busy}, 32'h0);
    // Bit 1 is still an input and qualifies normally
    pin_in = 8'h03;
    tick(3);
    check("b1_e3_busy", {31'h0, busy}, 32'h1);
    tick(3);
    check("b1_e6_flag", {31'h0, change_flag}, 32'h0);
    tick(1);
    check("b1_e7_flag", {31'h0, change_flag}, 32'h1);
    pulse_read();
    pulse_clear();
    inout_sel = 8'hFF;
    tick(2);
    check("b1_idle", {31'h0, busy}, 32'h0);
    check("b1_clr", {31'h0, change_flag}, 32'h0);

    // Collision: flag_clear on the qualify edge; bits 0 and 3 toggled (03 -> 0A)
    pin_in = 8'h0A;
    tick(6);
    check("c_e6_flag", {31'h0, change_flag}, 32'h0);
    flag_clear = 1'b1;
    tick(1);
    flag_clear = 1'b0;
    check("c_e7_flag", {31'h0, change_flag}, 32'h1);
`ifdef IOC_CAUSE_CAPTURE_EN
    check("c_cause", {24'h0, cause}, 32'h09);
`endif
    pulse_clear();
    check("c_clr_flag", {31'h0, change_flag}, 32'h0);
    check("c_armed_busy", {31'h0, busy}, 32'h1);
`ifdef IOC_CAUSE_CAPTURE_EN
    check("c_clr_cause", {24'h0, cause}, 32'h00);
`endif

    // Asynchronous reset in the middle of a debounce
    pulse_read();
    pin_in = 8'h00;
    tick(4);
    check("r_mid_busy", {31'h0, busy}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("r_async_flag", {31'h0, change_flag}, 32'h0);
    check("r_async_irq",  {31'h0, irq}, 32'h0);
    check("r_async_busy", {31'h0, busy}, 32'h0);
    check("r_async_port", {24'h0, port_value}, 32'h0);
    tick(2);
    check("r_hold_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    tick(8);
    check("r_after_flag", {31'h0, change_flag}, 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/io_change_detect.md
Name: io_change_detect

Overview:
- Sits directly upstream of the CPU interrupt logic and beside the bidirectional port register, on the input side of the I/O pins.
- Synchronizes the raw pin values and debounces changes on pins configured as inputs, modelled on the PIC "port change" feature.
- Raises a sticky change flag and an interrupt request when a qualified change occurs.
- A CPU read of the port re-arms the detector.

Parameters:
- WIDTH, 8: port width in bits.
- SYNC_STAGES, 2: synchronizer flop depth. Must be >= 2.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to qualify a change. Must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pin_in  in  WIDTH  raw pad values (the port pins).
- inout_sel  in  WIDTH  direction per bit; 1 = input (monitored), 0 = output (ignored).
- change_en  in  WIDTH  per-bit change-detect enable.
- global_ie  in  1  interrupt enable.
- read_strobe  in  1  CPU port-read pulse.
- flag_clear  in  1  clears change_flag.
- port_value  out  WIDTH  synchronized pin value (last sync stage).
- change_flag  out  1  sticky qualified-change flag.
- irq  out  1  interrupt request; irq = change_flag & global_ie (combinational).
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (asynchronous, reset_n = 0) clears all of the following, and they hold while reset_n is low:
  - sync flops, snapshot, candidate, counter and change_flag = 0;
  - state = IDLE;
  - port_value = 0, irq = 0, busy = 0.
- Reset mid-debounce aborts the debounce with no flag.
- Synchronizer: pin_in passes through SYNC_STAGES flops to give sync, which drives port_value. Latency is SYNC_STAGES edges.
- Derived terms:
  - mask = inout_sel & change_en;
  - mismatch = (sync ^ snapshot) & mask.
- FSM IDLE:
  - if mismatch != 0: go to DEBOUNCE, cnt <= 0, cand <= sync.
- FSM DEBOUNCE:
  - if mismatch == 0 (pin returned to snapshot, or its mask bit dropped): go to IDLE.
  - else if (sync ^ cand) & mask != 0: cand <= sync, cnt <= 0 (restart).
  - else if cnt == DEBOUNCE_CYCLES-1: change_flag <= 1, go to ARMED.
  - else cnt <= cnt+1.
- FSM ARMED:
  - no further detection; stay until read_strobe.
- read_strobe, in any state, has highest priority over all FSM transitions:
  - snapshot <= sync, state <= IDLE, cnt <= 0;
  - change_flag is not affected.
- flag_clear clears change_flag. If a set and flag_clear happen in the same cycle, the set wins and change_flag = 1.
- Timing with defaults, for a pin change set up before edge 1:
  - sync updates at edge 2;
  - DEBOUNCE entered at edge 3;
  - change_flag = 1 after edge 7;
  - general case: change_flag = 1 after edge SYNC_STAGES+1+DEBOUNCE_CYCLES.
- Bits with inout_sel = 0 or change_en = 0 never cause a transition. Direction changes are re-evaluated every cycle.
- The counter is $clog2(DEBOUNCE_CYCLES)+1 bits wide and cannot wrap; it is capped by the qualify condition.

Optional Feature:
- Macro: IOC_CAUSE_CAPTURE_EN.
- Defined: adds output cause [WIDTH], reset to 0.
  - On the qualify cycle: cause <= cause | ((cand ^ snapshot) & mask).
  - Cleared together with change_flag by flag_clear. If a qualify and flag_clear happen in the same cycle, cause = the new bits only.
- Undefined: no cause port and no cause register. All other behaviour is identical.

Test Plan:
1. Reset: assert reset_n = 0 mid-debounce -> change_flag = 0, irq = 0, busy = 0, port_value = 0 immediately (asynchronous).
2. Single-bit change, defaults, inout_sel = 8'hFF, change_en = 8'hFF, global_ie = 1: pin_in 8'h00 -> 8'h01 -> busy rises after edge 3; change_flag = 1 and irq = 1 after edge 7.
3. Glitch: pin_in = 8'h10 held for 2 cycles, then back to 8'h00 -> DEBOUNCE entered, returns to IDLE, change_flag stays 0.
4. Output pin: inout_sel = 8'hFE, toggle bit 0 -> busy = 0 and change_flag = 0 throughout. Then toggle bit 1 -> flag sets.
5. Re-arm: in ARMED, pulse read_strobe with sync = 8'h01 -> busy = 0, snapshot = 8'h01, change_flag stays 1. Pulse flag_clear -> change_flag = 0 and irq = 0.
6. Collision: flag_clear asserted on the qualify cycle -> change_flag = 1. With IOC_CAUSE_CAPTURE_EN defined: toggle bits 0 and 3 -> cause = 8'h09.
